// File: rtl/xif_gpio_bank.sv
// xif_gpio_bank: NUM_PORTS x PORT_WIDTH GPIO with synchronised inputs and edge interrupts on the xif bus.
// Rev 1.0
`default_nettype none

module xif_gpio_bank #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          NUM_PORTS   = 2,
  parameter int          PORT_WIDTH  = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            xif_req_i,
  input  logic                            xif_we_i,
  input  logic [31:0]                     xif_addr_bi,
  input  logic [3:0]                      xif_be_bi,
  input  logic [31:0]                     xif_wdata_bi,
  output logic                            xif_ack_o,
  output logic                            xif_resp_o,
  output logic [31:0]                     xif_rdata_bo,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_bi,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_bo,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe_bo,
  output logic                            irq_o
);

  localparam int          BUS_W    = NUM_PORTS * PORT_WIDTH;
  localparam logic [31:0] WINDOW   = 32'(NUM_PORTS * 32);
  localparam logic [2:0]  OFF_OUT  = 3'd0;
  localparam logic [2:0]  OFF_IN   = 3'd1;
  localparam logic [2:0]  OFF_DIR  = 3'd2;
  localparam logic [2:0]  OFF_RISE = 3'd3;
  localparam logic [2:0]  OFF_FALL = 3'd4;
  localparam logic [2:0]  OFF_STAT = 3'd5;

  logic [31:0]           offset;
  logic                  hit;
  logic [2:0]            port_idx;
  logic [2:0]            word;
  logic                  wr_en;
  logic                  rd_en;
  logic [31:0]           be_mask;
  logic [PORT_WIDTH-1:0] wmask;
  logic [PORT_WIDTH-1:0] wdat;
  logic [31:0]           rd_val;
  logic [NUM_PORTS*32-1:0] rd_flat;
  logic [BUS_W-1:0]      sync_q [SYNC_STAGES];
  logic [BUS_W-1:0]      in_all;
  logic [BUS_W-1:0]      prev_q;
  logic [BUS_W-1:0]      status_all;

  // Subtraction-based decode keeps the window check independent of BASE_ADDR alignment.
  assign offset   = xif_addr_bi - BASE_ADDR;
  assign hit      = (xif_addr_bi >= BASE_ADDR) && (offset < WINDOW);
  assign port_idx = offset[7:5];
  assign word     = offset[4:2];
  assign wr_en    = xif_req_i & xif_we_i & hit;
  assign rd_en    = xif_req_i & ~xif_we_i;
  assign be_mask  = {{8{xif_be_bi[3]}}, {8{xif_be_bi[2]}}, {8{xif_be_bi[1]}}, {8{xif_be_bi[0]}}};
  assign wmask    = be_mask[PORT_WIDTH-1:0];
  assign wdat     = xif_wdata_bi[PORT_WIDTH-1:0];

  assign xif_ack_o = xif_req_i;
  assign in_all    = sync_q[SYNC_STAGES-1];
  assign irq_o     = |status_all;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_bi;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= in_all;
    end
  end

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic                  sel;
      logic [PORT_WIDTH-1:0] out_q;
      logic [PORT_WIDTH-1:0] dir_q;
      logic [PORT_WIDTH-1:0] rise_en_q;
      logic [PORT_WIDTH-1:0] fall_en_q;
      logic [PORT_WIDTH-1:0] status_q;
      logic [PORT_WIDTH-1:0] pin_in;
      logic [PORT_WIDTH-1:0] pin_prev;
      logic [PORT_WIDTH-1:0] event_set;
      logic [PORT_WIDTH-1:0] clr;
      logic [31:0]           rd_word;

      assign sel       = wr_en && (port_idx == 3'(p));
      assign pin_in    = in_all[p*PORT_WIDTH +: PORT_WIDTH];
      assign pin_prev  = prev_q[p*PORT_WIDTH +: PORT_WIDTH];
      assign event_set = (pin_in & ~pin_prev & rise_en_q) | (~pin_in & pin_prev & fall_en_q);
      assign clr       = (sel && word == OFF_STAT) ? (wdat & wmask) : '0;

      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          out_q     <= '0;
          dir_q     <= '0;
          rise_en_q <= '0;
          fall_en_q <= '0;
          status_q  <= '0;
        end else begin
          if (sel && word == OFF_OUT)  out_q     <= (out_q & ~wmask) | (wdat & wmask);
          if (sel && word == OFF_DIR)  dir_q     <= (dir_q & ~wmask) | (wdat & wmask);
          if (sel && word == OFF_RISE) rise_en_q <= (rise_en_q & ~wmask) | (wdat & wmask);
          if (sel && word == OFF_FALL) fall_en_q <= (fall_en_q & ~wmask) | (wdat & wmask);
          // A new edge event takes priority over a simultaneous W1C.
          status_q <= (status_q & ~clr) | event_set;
        end
      end

      always_comb begin
        rd_word = '0;
        case (word)
          OFF_OUT:  rd_word[PORT_WIDTH-1:0] = out_q;
          OFF_IN:   rd_word[PORT_WIDTH-1:0] = pin_in;
          OFF_DIR:  rd_word[PORT_WIDTH-1:0] = dir_q;
          OFF_RISE: rd_word[PORT_WIDTH-1:0] = rise_en_q;
          OFF_FALL: rd_word[PORT_WIDTH-1:0] = fall_en_q;
          OFF_STAT: rd_word[PORT_WIDTH-1:0] = status_q;
          default:  rd_word = '0;
        endcase
      end

      assign rd_flat[p*32 +: 32]                   = rd_word;
      assign gpio_bo[p*PORT_WIDTH +: PORT_WIDTH]    = out_q;
      assign gpio_oe_bo[p*PORT_WIDTH +: PORT_WIDTH] = dir_q;
      assign status_all[p*PORT_WIDTH +: PORT_WIDTH] = status_q;
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (hit && port_idx == 3'(p)) rd_val = rd_flat[p*32 +: 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      xif_resp_o   <= 1'b0;
      xif_rdata_bo <= '0;
    end else begin
      xif_resp_o   <= rd_en;
      xif_rdata_bo <= rd_en ? rd_val : '0;
    end
  end

endmodule

`default_nettype wire
